// File: rtl/demux14_reg.sv
// ---------------------------------------------------------------------------
// demux14_reg
//   1-to-4 registered demultiplexer with valid/ready handshakes. One WIDTH-bit
//   word per transfer is taken from a single producer and steered to one of
//   four consumer channels chosen by sel. Each channel owns a one-entry output
//   register, so a stalled consumer only blocks words aimed at its channel.
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-low reset (0 = reset)
//   in_valid    in   1      producer presents a word on din/sel
//   in_ready    out  1      word is accepted this cycle (combinational)
//   sel         in   2      destination channel 0..3
//   din         in   WIDTH  data word
//   dout_0..3   out  WIDTH  per-channel data registers
//   dout_valid  out  4      bit n: channel n holds an undelivered word
//   dout_ready  in   4      bit n: consumer n takes its word this cycle
//   xfer_cnt    out  CNT_W  accepted-word counter, wraps silently
// ---------------------------------------------------------------------------
module demux14_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout_0,
    output logic [WIDTH-1:0] dout_1,
    output logic [WIDTH-1:0] dout_2,
    output logic [WIDTH-1:0] dout_3,
    output logic [3:0]       dout_valid,
    input  logic [3:0]       dout_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

    ch_state_t        r_state [4];
    logic [WIDTH-1:0] r_data  [4];
    logic [CNT_W-1:0] r_cnt;

    logic [3:0] w_sel_oh;
    logic [3:0] w_drain;
    logic [3:0] w_load;
    logic       w_accept;

    always_comb begin
        dout_valid = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            dout_valid[n] = (r_state[n] == CH_FULL);
        end
    end

    // Readiness looks only at the addressed channel: free, or emptying now.
    assign in_ready = reset & (~dout_valid[sel] | dout_ready[sel]);
    assign w_accept = in_valid & in_ready;
    assign w_sel_oh = 4'b0001 << sel;
    assign w_load   = w_sel_oh & {4{w_accept}};
    assign w_drain  = dout_valid & dout_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned n = 0; n < 4; n++) begin
                r_state[n] <= CH_EMPTY;
                r_data[n]  <= '0;
            end
            r_cnt <= '0;
        end else begin
            for (int unsigned n = 0; n < 4; n++) begin
                // Load wins over drain: a simultaneous drain and load keeps
                // the channel FULL with the new word (pass-through, no bubble).
                if (w_load[n]) begin
                    r_state[n] <= CH_FULL;
                    r_data[n]  <= din;
                end else if (w_drain[n]) begin
                    r_state[n] <= CH_EMPTY;
                end
            end
            if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign dout_0   = r_data[0];
    assign dout_1   = r_data[1];
    assign dout_2   = r_data[2];
    assign dout_3   = r_data[3];
    assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_demux14_reg.sv
// ---------------------------------------------------------------------------
// tb_demux14_reg
//   Directed and random stimulus for demux14_reg (CNT_W=4 so the counter
//   wraps quickly). A slot-occupancy model of the four channels predicts
//   every output each cycle.
// ---------------------------------------------------------------------------
module tb_demux14_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sel;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout_0, dout_1, dout_2, dout_3;
    logic [3:0]       dout_valid;
    logic [3:0]       dout_ready;
    logic [CNT_W-1:0] xfer_cnt;

    demux14_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .din        (din),
        .dout_0     (dout_0),
        .dout_1     (dout_1),
        .dout_2     (dout_2),
        .dout_3     (dout_3),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .xfer_cnt   (xfer_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: does slot n hold a word, what word it shows, and how
    // many words have been accepted in total since the last reset.
    bit          m_have [4];
    logic [31:0] m_word [4];
    int unsigned m_total;

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_have[n] = 1'b0;
            m_word[n] = '0;
        end
        m_total = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dout_of(input int n);
        case (n)
            0:       return dout_0;
            1:       return dout_1;
            2:       return dout_2;
            default: return dout_3;
        endcase
    endfunction

    // One clock: check outputs against the model mid-cycle, advance the
    // model by the cycle's inputs, then step past the next rising edge.
    task automatic cycle(input string tag);
        bit          exp_rdy;
        logic [3:0]  exp_valid;
        int          s;
        #3;
        s = int'(sel);
        exp_rdy = reset && (!m_have[s] || dout_ready[s]);
        for (int n = 0; n < 4; n++) exp_valid[n] = m_have[n];
        chk({tag, ".in_ready"},   64'(in_ready),   64'(exp_rdy));
        chk({tag, ".dout_valid"}, 64'(dout_valid), 64'(exp_valid));
        chk({tag, ".xfer_cnt"},   64'(xfer_cnt),   64'(m_total % 16));
        for (int n = 0; n < 4; n++)
            chk($sformatf("%s.dout_%0d", tag, n), 64'(dout_of(n)), 64'(m_word[n]));

        if (!reset) begin
            model_reset();
        end else begin
            for (int n = 0; n < 4; n++)
                if (m_have[n] && dout_ready[n]) m_have[n] = 1'b0;
            if (in_valid && exp_rdy) begin
                m_have[s] = 1'b1;
                m_word[s] = din;
                m_total++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        reset      = 1'b0;
        in_valid   = 1'b1;
        sel        = 2'd0;
        din        = 32'hDEAD_BEEF;
        dout_ready = 4'b0000;
        @(posedge clk);
        #1;

        // Reset held with in_valid high
        cycle("rst0");
        cycle("rst1");

        // Round robin with all consumers ready
        reset      = 1'b1;
        dout_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            din = 32'(i);
            cycle("rr");
        end
        in_valid = 1'b0;
        cycle("rr_idle");

        // Backpressure on channel 2
        dout_ready = 4'b1011;
        in_valid   = 1'b1;
        sel        = 2'd2;
        din        = 32'hA5A5_A5A5;
        cycle("bp_first");
        din = 32'h5A5A_5A5A;
        cycle("bp_stall0");
        cycle("bp_stall1");
        dout_ready = 4'b1111;
        cycle("bp_release");
        in_valid   = 1'b0;
        dout_ready = 4'b1011;
        cycle("bp_after");
        dout_ready = 4'b1111;
        cycle("bp_drain");

        // Isolation: channel 1 stalled full, channel 3 keeps flowing
        dout_ready = 4'b1101;
        in_valid   = 1'b1;
        sel        = 2'd1;
        din        = 32'h1111_0001;
        cycle("iso_fill1");
        sel = 2'd3;
        din = 32'd7;
        cycle("iso_send3");
        in_valid = 1'b0;
        cycle("iso_hold");
        cycle("iso_hold2");

        // Counter wrap: 17 accepts after a fresh reset
        reset = 1'b0;
        cycle("wrap_rst");
        reset      = 1'b1;
        dout_ready = 4'b1111;
        in_valid   = 1'b1;
        for (int i = 0; i < 17; i++) begin
            sel = 2'(i % 4);
            din = 32'h100 + 32'(i);
            cycle("wrap");
        end
        in_valid = 1'b0;
        cycle("wrap_end");

        // Reset mid-operation with channels 0 and 2 full and stalled
        dout_ready = 4'b1010;
        in_valid   = 1'b1;
        sel        = 2'd0;
        din        = 32'hC0C0_0000;
        cycle("mid_fill0");
        sel = 2'd2;
        din = 32'hC0C0_0002;
        cycle("mid_fill2");
        in_valid = 1'b0;
        cycle("mid_hold");
        reset = 1'b0;
        cycle("mid_rst");
        reset    = 1'b1;
        in_valid = 1'b1;
        sel      = 2'd2;
        din      = 32'h0BAD_F00D;
        cycle("mid_resume");
        in_valid = 1'b0;
        cycle("mid_resume2");

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(59, 0) != 0);
            in_valid   = ($urandom_range(3, 0) != 0);
            sel        = 2'($urandom_range(3, 0));
            din        = $urandom;
            dout_ready = 4'($urandom);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux14_reg.md
Name: demux14_reg

Overview:
- 1-to-4 registered demultiplexer with valid/ready handshakes; the inverse of the 4:1 result mux.
- Takes one WIDTH-bit word per transfer from a single producer and steers it to one of four consumer channels chosen by sel.
- Each channel has a one-entry output register, so a stalled consumer blocks only words aimed at it.
- Sits in the MIPS datapath wherever one result must be distributed to one of four sinks (e.g. writeback or forwarding targets).

Parameters:
- WIDTH, 32, data width of din and of each dout_n.
- CNT_W, 16, width of the accepted-transfer counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- in_valid  input  1  producer has a word on din/sel.
- in_ready  output  1  block accepts the word this cycle.
- sel  input  2  destination channel, 0..3; sampled with din.
- din  input  WIDTH  data word.
- dout_0  output  WIDTH  channel 0 data register.
- dout_1  output  WIDTH  channel 1 data register.
- dout_2  output  WIDTH  channel 2 data register.
- dout_3  output  WIDTH  channel 3 data register.
- dout_valid  output  4  bit n = channel n holds an undelivered word.
- dout_ready  input  4  bit n = consumer n takes the word this cycle.
- xfer_cnt  output  CNT_W  number of accepted input words.

Behaviour:
- Reset: on a rising edge with reset=0, dout_0..3 <= 0, dout_valid <= 4'b0000 and xfer_cnt <= 0. in_ready = 0 while reset=0.
- Per-channel state: EMPTY (valid=0) or FULL (valid=1), held in dout_valid[n].
- Drain: drain[n] = dout_valid[n] & dout_ready[n].
- in_ready is combinational: reset & (~dout_valid[sel] | dout_ready[sel]).
  - in_ready depends only on the selected channel.
  - in_ready never depends on in_valid.
- Accept: accept = in_valid & in_ready. On accept, at the next edge:
  - dout_sel <= din;
  - dout_valid[sel] <= 1;
  - xfer_cnt <= xfer_cnt + 1.
- Latency: a word accepted in cycle t is presented on dout_sel with dout_valid[sel]=1 in cycle t+1.
- Full throughput: one word per cycle is sustained when the consumers keep dout_ready high.
- Channel transitions:
  - EMPTY -> FULL on accept to n.
  - FULL -> EMPTY on drain[n] with no accept to n.
  - FULL -> FULL with new data on drain[n] and accept to n in the same cycle (pass-through; no bubble, no loss).
  - FULL and not draining: in_ready=0 for sel=n; the register holds.
- Stability: while dout_valid[n]=1 and dout_ready[n]=0, dout_n must not change.
- Empty channels: while dout_valid[n]=0, dout_n holds its last value (0 after reset).
- Isolation: words to other channels are accepted freely while channel n is stalled.
- Drains on any subset of channels may occur in the same cycle as an accept to any channel.
- dout_ready[n] while dout_valid[n]=0 is ignored.
- in_valid=0: sel and din are don't-care; no state changes except drains.
- Counter: xfer_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation: pending words are discarded; all channels go EMPTY the next cycle; xfer_cnt returns to 0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> in_ready=0; dout_valid=0000; xfer_cnt=0; dout_0..3=0.
- Round robin: dout_ready=1111; send sel=0,1,2,3 with din=0,1,2,3 on consecutive cycles -> dout_n=n with only dout_valid[n] high one cycle after each accept; in_ready stays 1; xfer_cnt=4.
- Backpressure: dout_ready[2]=0; send sel=2 din=32'hA5A5A5A5, then sel=2 din=32'h5A5A5A5A.
  - First word accepted; second sees in_ready=0.
  - dout_2 holds A5A5A5A5.
  - Raise dout_ready[2]: second word is accepted that same cycle, dout_2=5A5A5A5A next cycle, with no cycle where dout_valid[2]=0.
- Isolation: channel 1 stalled FULL; send sel=3 din=7 -> accepted immediately; dout_3=7; dout_1 and dout_valid[1] unchanged.
- Wrap: CNT_W=4; perform 17 accepts -> xfer_cnt reads F after 15 accepts, 0 after 16 and 1 after 17.
- Mid-operation reset: channels 0 and 2 FULL and stalled; pulse reset=0 for one cycle -> dout_valid=0000 and xfer_cnt=0 next cycle; normal accepts resume afterwards.
